// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use bubble, branch flush, memory-busy freeze and stall watchdog
// Optional HAZARD_STATS_EN adds 32-bit bubble/flush/freeze-cycle counters.
module hazard_control_unit #(
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IF_ID_Rs1,
  input  logic [4:0] IF_ID_Rs2,
  input  logic       IF_ID_uses_rs1,
  input  logic       IF_ID_uses_rs2,
  input  logic [4:0] ID_EX_Rd,
  input  logic       ID_EX_memread,
  input  logic       branch_taken,
  input  logic       mem_busy,
  output logic       pc_write,
  output logic       IF_ID_write,
  output logic       IF_ID_flush,
  output logic       ID_EX_bubble,
  output logic       ID_EX_flush,
  output logic       EX_MEM_flush,
  output logic       pipe_hold,
  output logic       stall_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stat_bubbles,
  output logic [31:0] stat_flushes,
  output logic [31:0] stat_freeze_cycles
`endif
);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_FREEZE = 1'b1;
  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(MAX_STALL);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_freeze_cnt;
  logic             r_flush_pend;
  logic             r_stall_timeout;

  logic             w_load_use;
  logic             w_flush;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_load_use = ID_EX_memread && (ID_EX_Rd != 5'd0) &&
                      ((IF_ID_uses_rs1 && (ID_EX_Rd == IF_ID_Rs1)) ||
                       (IF_ID_uses_rs2 && (ID_EX_Rd == IF_ID_Rs2)));
  assign w_flush    = branch_taken || r_flush_pend;
  assign w_cnt_next = (r_freeze_cnt == W_MAX) ? r_freeze_cnt : r_freeze_cnt + 1'b1;
  assign stall_timeout = r_stall_timeout;

  // Reset forces the free-running defaults regardless of any other input.
  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    pipe_hold    = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        pipe_hold   = 1'b1;
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
      end else if (w_flush) begin
        IF_ID_flush  = 1'b1;
        ID_EX_flush  = 1'b1;
        EX_MEM_flush = 1'b1;
      end else if (w_load_use) begin
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_RUN;
      r_freeze_cnt    <= '0;
      r_flush_pend    <= 1'b0;
      r_stall_timeout <= 1'b0;
    end else if (mem_busy) begin
      r_state      <= S_FREEZE;
      r_freeze_cnt <= w_cnt_next;
      if (branch_taken)
        r_flush_pend <= 1'b1;
      if (w_cnt_next == W_MAX)
        r_stall_timeout <= 1'b1;
    end else begin
      // Release: the held branch (if any) is applied combinationally this cycle.
      r_state      <= S_RUN;
      r_flush_pend <= 1'b0;
      if (r_state == S_FREEZE)
        r_freeze_cnt <= '0;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bubbles       <= '0;
      stat_flushes       <= '0;
      stat_freeze_cycles <= '0;
    end else begin
      stat_bubbles       <= stat_bubbles + 32'(ID_EX_bubble);
      stat_flushes       <= stat_flushes + 32'(ID_EX_flush);
      stat_freeze_cycles <= stat_freeze_cycles + 32'(pipe_hold);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - table, directed and random checks of hazard_control_unit against a reference model
module tb_hazard_control_unit;

  localparam int MAX = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, br, bz;
  logic       pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble;
  logic       ID_EX_flush, EX_MEM_flush, pipe_hold, stall_timeout;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_bubbles, stat_flushes, stat_freeze_cycles;
`endif

  always #5 clk = ~clk;

  hazard_control_unit #(.MAX_STALL(MAX), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_Rs1(rs1), .IF_ID_Rs2(rs2),
    .IF_ID_uses_rs1(u1), .IF_ID_uses_rs2(u2),
    .ID_EX_Rd(rd), .ID_EX_memread(mr),
    .branch_taken(br), .mem_busy(bz),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
    .pipe_hold(pipe_hold), .stall_timeout(stall_timeout)
`ifdef HAZARD_STATS_EN
    , .stat_bubbles(stat_bubbles), .stat_flushes(stat_flushes),
    .stat_freeze_cycles(stat_freeze_cycles)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state: branch owed across a freeze, length of the current busy run, sticky watchdog.
  bit m_pend;
  int m_run;
  bit m_to;
  int unsigned m_sb, m_sf, m_sh;
  logic [6:0] e_out;  // {pc, ifw, iff, bub, idf, exf, hold}

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, br;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic x1, input logic x2, input logic [4:0] d,
                       input logic m, input logic b, input logic busy);
    rst = r; rs1 = a1; rs2 = a2; u1 = x1; u2 = x2; rd = d; mr = m; br = b; bz = busy;
  endtask

  task automatic model_eval();
    bit lu;
    lu = mr && rd != 0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
    if (rst)               e_out = 7'b1100000;
    else if (bz)           e_out = 7'b0000001;
    else if (br || m_pend) e_out = 7'b1110110;
    else if (lu)           e_out = 7'b0001000;
    else                   e_out = 7'b1100000;
  endtask

  task automatic model_commit();
    if (rst) begin
      m_pend = 0; m_run = 0; m_to = 0; m_sb = 0; m_sf = 0; m_sh = 0;
    end else begin
      m_sb += e_out[3];
      m_sf += e_out[2];
      m_sh += e_out[0];
      if (bz) begin
        m_run++;
        if (m_run >= MAX) m_to = 1;
        if (br) m_pend = 1;
      end else begin
        m_run = 0;
        m_pend = 0;
      end
    end
  endtask

  function automatic logic [6:0] dut_out();
    return {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, ID_EX_flush, EX_MEM_flush, pipe_hold};
  endfunction

  task automatic sample(input string tag);
    @(negedge clk);
    model_eval();
    chk({tag, ".ctrl"}, 32'(dut_out()), 32'(e_out));
    chk({tag, ".timeout"}, 32'(stall_timeout), 32'(m_to));
`ifdef HAZARD_STATS_EN
    chk({tag, ".sb"}, stat_bubbles, m_sb);
    chk({tag, ".sf"}, stat_flushes, m_sf);
    chk({tag, ".sh"}, stat_freeze_cycles, m_sh);
`endif
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag);
    sample(tag);
    advance();
  endtask

  initial begin
    vecs.push_back('{"idle",       5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 7'b1100000});
    vecs.push_back('{"lu_rs2",     5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 7'b0001000});
    vecs.push_back('{"lu_rs1",     5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 7'b0001000});
    vecs.push_back('{"rd_zero",    5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 7'b1100000});
    vecs.push_back('{"rs2_unused", 5'd0, 5'd5, 0, 0, 5'd5, 1, 0, 7'b1100000});
    vecs.push_back('{"not_load",   5'd5, 5'd5, 1, 1, 5'd5, 0, 0, 7'b1100000});
    vecs.push_back('{"br_over_lu", 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 7'b1110110});
    vecs.push_back('{"br_only",    5'd1, 5'd2, 0, 0, 5'd3, 0, 1, 7'b1110110});
    vecs.push_back('{"rs1_unused", 5'd9, 5'd4, 0, 1, 5'd9, 1, 0, 7'b1100000});

    // Reset cycle with every hazard input active: outputs must be the free-run defaults.
    drive(1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1);
    @(negedge clk);
    chk("reset.ctrl", 32'(dut_out()), 32'(7'b1100000));
    model_eval();
    advance();
    drive(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0);
    step("post_reset");

    foreach (vecs[i]) begin
      drive(0, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
            vecs[i].mr, vecs[i].br, 0);
      @(negedge clk);
      model_eval();
      chk({"tbl.", vecs[i].name}, 32'(dut_out()), 32'(vecs[i].exp));
      chk({"tbl.", vecs[i].name, ".timeout"}, 32'(stall_timeout), 32'(m_to));
      advance();
    end

    // Single bubble, then the load has moved on.
    drive(0, 5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0);
    sample("lu1");
    chk("lu1.bubble", 32'(ID_EX_bubble), 1);
    advance();
    drive(0, 5'd0, 5'd5, 0, 1, 5'd5, 0, 0, 0);
    sample("lu2");
    chk("lu2.pc_write", 32'(pc_write), 1);
    advance();

    // Three busy cycles, branch on the second; flush owed until release.
    for (int c = 1; c <= 3; c++) begin
      drive(0, 5'd0, 5'd5, 0, 1, 5'd5, 1, (c == 2), 1);
      sample($sformatf("frz%0d", c));
      chk($sformatf("frz%0d.noflush", c), 32'(ID_EX_flush), 0);
      advance();
    end
    drive(0, 5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0);
    sample("frz_rel");
    chk("frz_rel.flush", 32'({IF_ID_flush, ID_EX_flush, EX_MEM_flush, ID_EX_bubble}), 32'(4'b1110));
    advance();
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    sample("frz_after");
    chk("frz_after.flush", 32'(ID_EX_flush), 0);
    advance();

    // Watchdog: visible once four busy cycles have been counted, sticky after release.
    for (int c = 1; c <= 6; c++) begin
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
      sample($sformatf("wd%0d", c));
      chk($sformatf("wd%0d.to", c), 32'(stall_timeout), 32'(c >= 5));
      advance();
    end
    for (int c = 0; c < 3; c++) begin
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
      sample($sformatf("wd_rel%0d", c));
      chk($sformatf("wd_rel%0d.to", c), 32'(stall_timeout), 1);
      advance();
    end

    // Reset mid-freeze discards the pending flush and clears the watchdog.
    for (int c = 0; c < 5; c++) begin
      drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, (c == 1), 1);
      step($sformatf("rf%0d", c));
    end
    drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
    step("rf_rst");
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    sample("rf_after");
    chk("rf_after.ctrl", 32'(dut_out()), 32'(7'b1100000));
    chk("rf_after.to", 32'(stall_timeout), 0);
`ifdef HAZARD_STATS_EN
    chk("rf_after.stats", stat_bubbles | stat_flushes | stat_freeze_cycles, 0);
`endif
    advance();

    // Random traffic against the model.
    begin
      int busy_left = 0;
      for (int i = 0; i < 600; i++) begin
        logic b;
        if (busy_left > 0) begin
          b = 1; busy_left--;
        end else if ($urandom_range(0, 5) == 0) begin
          b = 1; busy_left = $urandom_range(0, 6);
        end else begin
          b = 0;
        end
        drive(($urandom_range(0, 59) == 0),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 4) == 0), b);
        step($sformatf("rnd%0d", i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
